sparc_pc_decode_core: RTL and testbench
=======================================

Name: sparc_pc_decode_core

Overview:
- Front-end datapath slice of the 5-stage SPARC pipeline. It has three parts:
  - the program-counter register with its next-PC source select;
  - the constant +4 incrementer;
  - the combinational instruction decoder that produces the 19-bit ID-stage control vector.
- Sits between the hazard/branch logic (which drives le and mux_select) and the IF/ID and ID/EX pipeline registers.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, increment applied by the adder.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous active-high reset.
- le  in  1  PC load enable; 0 holds PC (stall).
- mux_select  in  2  next-PC source: 00 npc, 01 ta, 10 alu_out, 11 hold.
- ta  in  32  branch/call target address.
- alu_out  in  32  jmpl target from the ALU.
- instr  in  32  instruction held in IF/ID.
- pc  out  32  current PC (fetch address).
- npc  out  32  pc + PC_STEP, combinational.
- instr_signals  out  19  decoded control vector.

Behaviour:
- PC register, on rising clk:
  - clr=1: pc <= RESET_PC, regardless of le or mux_select.
  - else if le=1: pc <= selected source.
  - else: hold.
  - Reset value of pc is 0, so npc = 4 during reset.
- Adder: npc = pc + 4 modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000), zero latency.
- Decoder is purely combinational, zero latency, and unaffected by clk/clr. Vector bit map:
  - [0] jmpl, [1] call, [2] load, [3] reg-file write enable.
  - [4] data-mem sign-extend, [5] data-mem R/W (1 = write), [6] data-mem enable.
  - [8:7] size (00 byte, 01 half, 10 word).
  - [9] cond-code enable.
  - [10] instr[31], [11] instr[30], [12] instr[24], [13] instr[13] (raw copies).
  - [17:14] ALU opcode, [18] branch.
- ALU opcodes:
  - ADD 0000, AND 0001, OR 0010, XOR 0011, SUB 0100, ANDN 0101, ORN 0110, XNOR 0111.
  - ADDX 1000, SUBX 1100, SLL 1010, SRL 1011, SRA 1101, PASSB 1110.
- op=01 (call): call=1, regen=1, ALU ADD.
- op=00, op2=instr[24:22]:
  - 100 SETHI: regen=1, ALU PASSB.
  - 010 Bicc: branch=1.
  - Any other op2: all control bits 0.
- op=10, op3=instr[24:19]:
  - Arithmetic/logic with op3[5]=0: ALU = op3[3:0], cc enable = op3[4], regen=1.
  - 100101 SLL, 100110 SRL, 100111 SRA: regen=1.
  - 111000 jmpl: jmpl=1, regen=1, ALU ADD.
  - Other op3: control bits 0.
- op=11 (memory), ALU ADD, E=1:
  - Load = op3[2]=0: load=1, regen=1, SE=op3[3].
  - Store: R/W=1.
  - Size from op3[1:0]: 00 word, 01 byte, 10 half.
- All-zero instruction decodes to an all-zero vector (bubble).
- Simultaneous clr and le: clr wins.
- Reset mid-stall: clr still clears pc.

Decomposition:
- Shared package sparc_pkg holds:
  - ALU opcode constants;
  - the control-vector bit-index constants;
  - the size codes;
  - the mux_select codes.
- One natural sub-module: sparc_instr_decoder (the combinational decoder).
- Adder and PC register stay inline.

Test Plan:
- Reset then run: clr=1 one edge, then clr=0, le=1, sel=00 for 3 edges -> pc = 0, 4, 8, 12; npc always pc+4.
- Redirect and stall:
  - sel=01, ta=0x40 -> pc=0x40.
  - sel=10, alu_out=0x80 -> pc=0x80.
  - le=0 for 2 edges -> pc stays 0x80.
  - clr during le=0 -> pc=0.
- Wrap: force pc=0xFFFF_FFFC via ta, then sel=00 -> npc=0, next pc=0.
- ADD r1,r2,r3 (instr 0x86004002) -> instr_signals=0x00408 (regen, I31, ALU 0000).
- LD [r1+4],r2 (0xC4006004) -> instr_signals=0x02D4C. call 0x40000004 -> 0x0080A. instr 0x00000000 -> 0x00000.
- SUBcc (op3=010100) -> ALU 0100, bit9=1. BA (0x10800002) -> bit18=1, bit3=0. ST (op3=000100) -> bits 5,6 set, bit2=0.

Source files
------------

// File: rtl/sparc_pkg.sv
// Shared definitions for the SPARC front-end slice (PC + decoder).
// Holds the ALU opcode constants, the bit positions inside the 19-bit
// ID-stage control vector, the memory access size codes, the next-PC
// source codes and a small helper that maps a memory op3 size field
// onto the size code carried in the control vector.
package sparc_pkg;

    // Width of the decoded control vector
    localparam int unsigned CTRL_W = 19;

    // ALU opcodes
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_AND   = 4'b0001;
    localparam logic [3:0] ALU_OR    = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0100;
    localparam logic [3:0] ALU_ANDN  = 4'b0101;
    localparam logic [3:0] ALU_ORN   = 4'b0110;
    localparam logic [3:0] ALU_XNOR  = 4'b0111;
    localparam logic [3:0] ALU_ADDX  = 4'b1000;
    localparam logic [3:0] ALU_SUBX  = 4'b1100;
    localparam logic [3:0] ALU_SLL   = 4'b1010;
    localparam logic [3:0] ALU_SRL   = 4'b1011;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_PASSB = 4'b1110;

    // Control-vector bit positions
    localparam int unsigned SIG_JMPL    = 0;
    localparam int unsigned SIG_CALL    = 1;
    localparam int unsigned SIG_LOAD    = 2;
    localparam int unsigned SIG_REGEN   = 3;
    localparam int unsigned SIG_SE      = 4;
    localparam int unsigned SIG_RW      = 5;
    localparam int unsigned SIG_MEM_EN  = 6;
    localparam int unsigned SIG_SIZE_LO = 7;
    localparam int unsigned SIG_SIZE_HI = 8;
    localparam int unsigned SIG_CC_EN   = 9;
    localparam int unsigned SIG_I31     = 10;
    localparam int unsigned SIG_I30     = 11;
    localparam int unsigned SIG_I24     = 12;
    localparam int unsigned SIG_I13     = 13;
    localparam int unsigned SIG_ALU_LO  = 14;
    localparam int unsigned SIG_ALU_HI  = 17;
    localparam int unsigned SIG_BRANCH  = 18;

    // Memory access size codes
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Next-PC source select codes
    localparam logic [1:0] SEL_NPC  = 2'b00;
    localparam logic [1:0] SEL_TA   = 2'b01;
    localparam logic [1:0] SEL_ALU  = 2'b10;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    // Instruction format (op field) codes
    localparam logic [1:0] OP_FMT2  = 2'b00;
    localparam logic [1:0] OP_CALL  = 2'b01;
    localparam logic [1:0] OP_ARITH = 2'b10;
    localparam logic [1:0] OP_MEM   = 2'b11;

    // Format-2 op2 codes
    localparam logic [2:0] OP2_BICC  = 3'b010;
    localparam logic [2:0] OP2_SETHI = 3'b100;

    // Format-3 arithmetic op3 codes needing explicit decode
    localparam logic [5:0] OP3_SLL  = 6'b100101;
    localparam logic [5:0] OP3_SRL  = 6'b100110;
    localparam logic [5:0] OP3_SRA  = 6'b100111;
    localparam logic [5:0] OP3_JMPL = 6'b111000;

    // Memory op3[1:0] encodes 00 word, 01 byte, 10 half; 11 (doubleword)
    // is not supported by this datapath and is treated as a word access.
    function automatic logic [1:0] mem_size(input logic [1:0] op3_lo);
        logic [1:0] size;
        case (op3_lo)
            2'b00:   size = SIZE_WORD;
            2'b01:   size = SIZE_BYTE;
            2'b10:   size = SIZE_HALF;
            default: size = SIZE_WORD;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/sparc_instr_decoder.sv
// Combinational SPARC instruction decoder.
// Ports:
//   instr         in  32  instruction held in IF/ID
//   instr_signals out 19  ID-stage control vector (bit map in sparc_pkg)
// Raw copies of instr[31], instr[30], instr[24] and instr[13] are always
// forwarded; all other bits are driven from the op/op2/op3 decode.
module sparc_instr_decoder
    import sparc_pkg::*;
(
    input  logic [31:0]       instr,
    output logic [CTRL_W-1:0] instr_signals
);

    logic [1:0]        op_s;
    logic [2:0]        op2_s;
    logic [5:0]        op3_s;
    logic [CTRL_W-1:0] sig_s;
    logic              unused_s;

    assign op_s  = instr[31:30];
    assign op2_s = instr[24:22];
    assign op3_s = instr[24:19];

    // Register fields and immediates are consumed downstream, not here
    assign unused_s = ^{instr[29:25], instr[18:14], instr[12:0]};

    // Decode op/op2/op3 into the control vector
    always_comb begin
        sig_s = '0;
        sig_s[SIG_I31] = instr[31];
        sig_s[SIG_I30] = instr[30];
        sig_s[SIG_I24] = instr[24];
        sig_s[SIG_I13] = instr[13];
        case (op_s)
            OP_CALL: begin
                sig_s[SIG_CALL]                = 1'b1;
                sig_s[SIG_REGEN]               = 1'b1;
                sig_s[SIG_ALU_HI:SIG_ALU_LO]   = ALU_ADD;
            end
            OP_FMT2: begin
                case (op2_s)
                    OP2_SETHI: begin
                        sig_s[SIG_REGEN]             = 1'b1;
                        sig_s[SIG_ALU_HI:SIG_ALU_LO] = ALU_PASSB;
                    end
                    OP2_BICC: begin
                        sig_s[SIG_BRANCH] = 1'b1;
                    end
                    default: begin
                        sig_s[SIG_BRANCH] = 1'b0;
                    end
                endcase
            end
            OP_ARITH: begin
                // op3[5]=0 is the regular ALU group: op3[4] is the "cc" flag
                // and op3[3:0] is the ALU opcode itself.
                if (op3_s[5] == 1'b0) begin
                    sig_s[SIG_ALU_HI:SIG_ALU_LO] = op3_s[3:0];
                    sig_s[SIG_CC_EN]             = op3_s[4];
                    sig_s[SIG_REGEN]             = 1'b1;
                end else begin
                    case (op3_s)
                        OP3_SLL: begin
                            sig_s[SIG_REGEN]             = 1'b1;
                            sig_s[SIG_ALU_HI:SIG_ALU_LO] = ALU_SLL;
                        end
                        OP3_SRL: begin
                            sig_s[SIG_REGEN]             = 1'b1;
                            sig_s[SIG_ALU_HI:SIG_ALU_LO] = ALU_SRL;
                        end
                        OP3_SRA: begin
                            sig_s[SIG_REGEN]             = 1'b1;
                            sig_s[SIG_ALU_HI:SIG_ALU_LO] = ALU_SRA;
                        end
                        OP3_JMPL: begin
                            sig_s[SIG_JMPL]              = 1'b1;
                            sig_s[SIG_REGEN]             = 1'b1;
                            sig_s[SIG_ALU_HI:SIG_ALU_LO] = ALU_ADD;
                        end
                        default: begin
                            sig_s[SIG_REGEN] = 1'b0;
                        end
                    endcase
                end
            end
            OP_MEM: begin
                // Address is always rs1 + operand2, so the ALU adds
                sig_s[SIG_MEM_EN]                = 1'b1;
                sig_s[SIG_ALU_HI:SIG_ALU_LO]     = ALU_ADD;
                sig_s[SIG_SIZE_HI:SIG_SIZE_LO]   = mem_size(op3_s[1:0]);
                if (op3_s[2] == 1'b0) begin
                    sig_s[SIG_LOAD]  = 1'b1;
                    sig_s[SIG_REGEN] = 1'b1;
                    sig_s[SIG_SE]    = op3_s[3];
                end else begin
                    sig_s[SIG_RW] = 1'b1;
                end
            end
            default: begin
                sig_s[SIG_REGEN] = 1'b0;
            end
        endcase
    end

    assign instr_signals = sig_s;

endmodule

// File: rtl/sparc_pc_decode_core.sv
// SPARC front-end slice: program counter, +PC_STEP incrementer and the
// ID-stage instruction decoder.
// Ports:
//   clk           in  1   rising-edge clock
//   clr           in  1   synchronous active-high reset (beats le)
//   le            in  1   PC load enable, 0 stalls the PC
//   mux_select    in  2   next-PC source: 00 npc, 01 ta, 10 alu_out, 11 hold
//   ta            in  32  branch/call target
//   alu_out       in  32  jmpl target from the ALU
//   instr         in  32  instruction held in IF/ID
//   pc            out 32  current fetch address
//   npc           out 32  pc + PC_STEP (combinational, wraps at 2^32)
//   instr_signals out 19  decoded control vector (combinational)
module sparc_pc_decode_core
    import sparc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              le,
    input  logic [1:0]        mux_select,
    input  logic [31:0]       ta,
    input  logic [31:0]       alu_out,
    input  logic [31:0]       instr,
    output logic [31:0]       pc,
    output logic [31:0]       npc,
    output logic [CTRL_W-1:0] instr_signals
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] npc_s;
    logic [31:0] src_s;

    // Incrementer; natural 32-bit overflow gives the required wrap
    assign npc_s = pc_q + PC_STEP;

    // Next-PC source select and stall
    always_comb begin
        src_s = pc_q;
        case (mux_select)
            SEL_NPC:  src_s = npc_s;
            SEL_TA:   src_s = ta;
            SEL_ALU:  src_s = alu_out;
            SEL_HOLD: src_s = pc_q;
            default:  src_s = pc_q;
        endcase
        if (le) begin
            pc_d = src_s;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register; clr overrides any load or stall
    always_ff @(posedge clk) begin
        if (clr) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    sparc_instr_decoder u_decoder (
        .instr         (instr),
        .instr_signals (instr_signals)
    );

    assign pc  = pc_q;
    assign npc = npc_s;

endmodule

// File: tb/tb_sparc_pc_decode_core.sv
module tb_sparc_pc_decode_core;

    logic        clk;
    logic        clr;
    logic        le;
    logic [1:0]  mux_select;
    logic [31:0] ta;
    logic [31:0] alu_out;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [18:0] instr_signals;

    int vectors;
    int miscompares;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [18:0] sig;
    } exp_t;

    exp_t exp_q[$];

    sparc_pc_decode_core dut (
        .clk           (clk),
        .clr           (clr),
        .le            (le),
        .mux_select    (mux_select),
        .ta            (ta),
        .alu_out       (alu_out),
        .instr         (instr),
        .pc            (pc),
        .npc           (npc),
        .instr_signals (instr_signals)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: on each falling edge, check every pending expectation
    initial begin : monitor
        exp_t e;
        logic [31:0] exp_npc;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                exp_npc = e.pc + 32'd4;
                vectors++;
                if (pc !== e.pc) begin
                    miscompares++;
                    $display("FAIL %s pc: got %08h expected %08h", e.name, pc, e.pc);
                end
                vectors++;
                if (npc !== exp_npc) begin
                    miscompares++;
                    $display("FAIL %s npc: got %08h expected %08h", e.name, npc, exp_npc);
                end
                vectors++;
                if (instr_signals !== e.sig) begin
                    miscompares++;
                    $display("FAIL %s sig: got %05h expected %05h", e.name, instr_signals, e.sig);
                end
            end
        end
    end

    // Drive one cycle of inputs, then queue the state expected after the edge
    task automatic step(input logic c, input logic l, input logic [1:0] s,
                        input logic [31:0] t, input logic [31:0] a,
                        input logic [31:0] i, input string nm,
                        input logic [31:0] epc, input logic [18:0] esig);
        exp_t e;
        clr        = c;
        le         = l;
        mux_select = s;
        ta         = t;
        alu_out    = a;
        instr      = i;
        @(posedge clk);
        #1;
        e.name = nm;
        e.pc   = epc;
        e.sig  = esig;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin : stimulus
        vectors     = 0;
        miscompares = 0;
        clr        = 1'b1;
        le         = 1'b0;
        mux_select = 2'b00;
        ta         = 32'h0;
        alu_out    = 32'h0;
        instr      = 32'h0;
        #2;
        //    clr   le    sel    ta            alu_out       instr         name       pc            sig
        step(1'b1, 1'b0, 2'b00, 32'h0,        32'h0,        32'h00000000, "reset",   32'h00000000, 19'h00000);
        step(1'b0, 1'b1, 2'b00, 32'h0,        32'h0,        32'h86004002, "run4",    32'h00000004, 19'h00408);
        step(1'b0, 1'b1, 2'b00, 32'h0,        32'h0,        32'hC4006004, "run8",    32'h00000008, 19'h02D4C);
        step(1'b0, 1'b1, 2'b00, 32'h0,        32'h0,        32'h40000004, "run12",   32'h0000000C, 19'h0080A);
        step(1'b0, 1'b1, 2'b01, 32'h40,       32'h0,        32'h10800002, "ta",      32'h00000040, 19'h40000);
        step(1'b0, 1'b1, 2'b10, 32'h40,       32'h80,       32'h82A08003, "alu",     32'h00000080, 19'h10608);
        step(1'b0, 1'b0, 2'b01, 32'h40,       32'h0,        32'hC220A008, "stall1",  32'h00000080, 19'h02D60);
        step(1'b0, 1'b0, 2'b00, 32'h40,       32'h0,        32'h03000000, "stall2",  32'h00000080, 19'h39008);
        step(1'b1, 1'b0, 2'b00, 32'h0,        32'h0,        32'h83282003, "clrstl",  32'h00000000, 19'h2B408);
        step(1'b1, 1'b1, 2'b01, 32'h40,       32'h0,        32'h81C04000, "clrwin",  32'h00000000, 19'h01409);
        step(1'b0, 1'b1, 2'b11, 32'h40,       32'h80,       32'hC4486001, "hold",    32'h00000000, 19'h02C5C);
        step(1'b0, 1'b1, 2'b01, 32'hFFFFFFFC, 32'h0,        32'hC2100000, "wrapta",  32'hFFFFFFFC, 19'h00CCC);
        step(1'b0, 1'b1, 2'b00, 32'h0,        32'h0,        32'h00000005, "wrap",    32'h00000000, 19'h00000);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
